// File: rtl/sprite_addr_gen.sv
// Sprite ROM address generator and vsync-timed animation sequencer.
// Build option: define SPRITE_MIRROR_EN to enable horizontal mirroring via the flip port.
module sprite_addr_gen #(
   parameter int unsigned SPRITE_W   = 64,
   parameter int unsigned SPRITE_H   = 112,
   parameter int unsigned FRAMES     = 8,
   parameter int unsigned FRAME_HOLD = 6
) (
   input  logic        vga_clk,
   input  logic        reset,
   input  logic [9:0]  draw_x,
   input  logic [9:0]  draw_y,
   input  logic        vsync,
   input  logic [9:0]  pos_x,
   input  logic [9:0]  pos_y,
   input  logic        flip,
   input  logic        anim_start,
   input  logic        loop,
   output logic [15:0] rom_address,
   output logic        sprite_on,
   output logic [2:0]  frame_idx,
   output logic        anim_done
);

   localparam int unsigned AW       = 24;
   localparam int unsigned FRAME_SZ = SPRITE_W * SPRITE_H;
   localparam int unsigned HW       = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

   typedef enum logic {IDLE, PLAY} state_t;

   state_t          state;
   logic            vsync_q;
   logic            tick;
   logic [9:0]      px;
   logic [9:0]      py;
   logic [HW-1:0]   hold;
   logic            loop_l;
   logic            fl;

   logic [10:0]     dx, dy, pxe, pye;
   logic            hx, hy, on_d;
   logic [10:0]     col, row, col_m;
   logic [AW-1:0]   addr_full;

   assign tick = vsync_q & ~vsync;

   // Position (and facing) only change on the vsync falling edge, so no mid-frame tearing
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         vsync_q <= 1'b0;
         px      <= '0;
         py      <= '0;
      end else begin
         vsync_q <= vsync;
         if (tick) begin
            px <= pos_x;
            py <= pos_y;
         end
      end
   end

`ifdef SPRITE_MIRROR_EN
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset)     fl <= 1'b0;
      else if (tick) fl <= flip;
   end
`else
   assign fl = 1'b0;
   logic unused_flip;
   assign unused_flip = flip;
`endif

   // Hit test widened to 11 bits so the box never wraps past column/row 1023
   always_comb begin
      dx   = {1'b0, draw_x};
      dy   = {1'b0, draw_y};
      pxe  = {1'b0, px};
      pye  = {1'b0, py};
      hx   = (dx >= pxe) && (dx < pxe + 11'(SPRITE_W));
      hy   = (dy >= pye) && (dy < pye + 11'(SPRITE_H));
      on_d = hx & hy;
      col  = dx - pxe;
      row  = dy - pye;
`ifdef SPRITE_MIRROR_EN
      col_m = fl ? (11'(SPRITE_W - 1) - col) : col;
`else
      col_m = col | {10'd0, fl};
`endif
      addr_full = AW'(frame_idx) * AW'(FRAME_SZ)
                + AW'(row) * AW'(SPRITE_W)
                + AW'(col_m);
   end

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         rom_address <= '0;
         sprite_on   <= 1'b0;
      end else begin
         rom_address <= on_d ? addr_full[15:0] : 16'd0;
         sprite_on   <= on_d;
      end
   end

   // Animation sequencer; a start pulse overrides any coincident tick
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         frame_idx <= '0;
         hold      <= '0;
         loop_l    <= 1'b0;
         anim_done <= 1'b0;
      end else begin
         anim_done <= 1'b0;
         if (anim_start) begin
            state     <= PLAY;
            frame_idx <= '0;
            hold      <= '0;
            loop_l    <= loop;
         end else begin
            case (state)
               IDLE: begin
                  frame_idx <= '0;
                  hold      <= '0;
               end
               PLAY: begin
                  if (tick) begin
                     if (hold == HW'(FRAME_HOLD - 1)) begin
                        hold <= '0;
                        if (frame_idx == 3'(FRAMES - 1)) begin
                           anim_done <= 1'b1;
                           frame_idx <= '0;
                           if (!loop_l) state <= IDLE;
                        end else begin
                           frame_idx <= frame_idx + 3'd1;
                        end
                     end else begin
                        hold <= hold + HW'(1);
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sprite_addr_gen.sv
// Directed self-checking bench for sprite_addr_gen (default parameters).
module tb_sprite_addr_gen;

   logic        vga_clk = 1'b0;
   logic        reset;
   logic [9:0]  draw_x, draw_y, pos_x, pos_y;
   logic        vsync, flip, anim_start, loop;
   logic [15:0] rom_address;
   logic        sprite_on;
   logic [2:0]  frame_idx;
   logic        anim_done;

   int tests  = 0;
   int failed = 0;

   sprite_addr_gen dut (
      .vga_clk    (vga_clk),
      .reset      (reset),
      .draw_x     (draw_x),
      .draw_y     (draw_y),
      .vsync      (vsync),
      .pos_x      (pos_x),
      .pos_y      (pos_y),
      .flip       (flip),
      .anim_start (anim_start),
      .loop       (loop),
      .rom_address(rom_address),
      .sprite_on  (sprite_on),
      .frame_idx  (frame_idx),
      .anim_done  (anim_done)
   );

   always #5 vga_clk = ~vga_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      vsync = 1'b1;
      @(negedge vga_clk);
      vsync = 1'b0;
      @(negedge vga_clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic draw(input int x, input int y);
      draw_x = 10'(x);
      draw_y = 10'(y);
      @(negedge vga_clk);
   endtask

   task automatic start(input logic l);
      anim_start = 1'b1;
      loop       = l;
      @(negedge vga_clk);
      anim_start = 1'b0;
   endtask

   initial begin
      reset = 1'b1; vsync = 1'b0; flip = 1'b0; anim_start = 1'b0; loop = 1'b0;
      draw_x = '0; draw_y = '0; pos_x = 10'd100; pos_y = 10'd200;
      @(negedge vga_clk);
      @(negedge vga_clk);
      check("rst_addr",  rom_address, 0);
      check("rst_on",    sprite_on, 0);
      check("rst_frame", frame_idx, 0);
      check("rst_done",  anim_done, 0);
      reset = 1'b0;
      @(negedge vga_clk);

      // Latch position and check plain addressing
      tick();
      check("idle_frame", frame_idx, 0);
      draw(100, 200);
      check("tl_on", sprite_on, 1);
      check("tl_addr", rom_address, 0);
      draw(163, 311);
      check("br_on", sprite_on, 1);
      check("br_addr", rom_address, 7167);
      draw(164, 200);
      check("right_off_on", sprite_on, 0);
      check("right_off_addr", rom_address, 0);
      draw(99, 200);
      check("left_off_on", sprite_on, 0);
      draw(100, 312);
      check("below_off_on", sprite_on, 0);

      // Mirror
      flip = 1'b1;
      tick();
      draw(100, 200);
`ifdef SPRITE_MIRROR_EN
      check("mir_tl", rom_address, 63);
`else
      check("nomir_tl", rom_address, 0);
`endif
      draw(163, 200);
`ifdef SPRITE_MIRROR_EN
      check("mir_tr", rom_address, 0);
`else
      check("nomir_tr", rom_address, 63);
`endif
      flip = 1'b0;
      tick();

      // Position change mid-frame is ignored until the next tick
      pos_x = 10'd300;
      @(negedge vga_clk);
      draw(100, 200);
      check("midframe_on", sprite_on, 1);
      check("midframe_addr", rom_address, 0);

      // Right-edge box, no wrap
      pos_x = 10'd600;
      tick();
      draw(639, 200);
      check("edge_on", sprite_on, 1);
      check("edge_addr", rom_address, 39);
      draw(0, 200);
      check("nowrap_on", sprite_on, 0);
      pos_x = 10'd100;
      tick();

      // Play once
      start(1'b0);
      ticks(5);
      check("once_t5", frame_idx, 0);
      tick();
      check("once_t6", frame_idx, 1);
      draw(100, 200);
      check("once_f1_addr", rom_address, 7168);
      ticks(41);
      check("once_t47", frame_idx, 7);
      check("once_t47_done", anim_done, 0);
      tick();
      check("once_t48_done", anim_done, 1);
      check("once_t48_frame", frame_idx, 0);
      @(negedge vga_clk);
      check("once_done_pulse", anim_done, 0);
      ticks(6);
      check("once_idle_frame", frame_idx, 0);

      // Loop
      start(1'b1);
      ticks(47);
      check("loop_t47", frame_idx, 7);
      tick();
      check("loop_t48_done", anim_done, 1);
      check("loop_t48_frame", frame_idx, 0);
      ticks(6);
      check("loop_t54", frame_idx, 1);
      ticks(41);
      check("loop_t95_done", anim_done, 0);
      tick();
      check("loop_t96_done", anim_done, 1);
      ticks(6);
      check("loop_t102", frame_idx, 1);

      // Restart coincident with tick: restart wins, position still latched
      ticks(3);
      vsync = 1'b1;
      @(negedge vga_clk);
      vsync = 1'b0; anim_start = 1'b1; loop = 1'b1; pos_x = 10'd300;
      @(negedge vga_clk);
      anim_start = 1'b0;
      check("restart_frame", frame_idx, 0);
      draw(300, 200);
      check("restart_pos_on", sprite_on, 1);
      ticks(5);
      check("restart_t5", frame_idx, 0);
      tick();
      check("restart_t6", frame_idx, 1);

      // Reset mid-play at frame 4
      ticks(18);
      check("pre_rst_frame", frame_idx, 4);
      draw(300, 200);
      check("pre_rst_addr", rom_address, 28672);
      #2;
      reset = 1'b1;
      #1;
      check("async_addr", rom_address, 0);
      check("async_on", sprite_on, 0);
      check("async_frame", frame_idx, 0);
      check("async_done", anim_done, 0);
      @(negedge vga_clk);
      reset = 1'b0;
      ticks(6);
      check("post_rst_frame", frame_idx, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
